// File: rtl/sync_updown_mod.sv
// Parametrised synchronous up/down counter with modulus, parallel load,
// wrap or saturate boundary handling, terminal-count pulse and sticky overflow.
module sync_updown_mod #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_COUNT = 15,
    parameter int unsigned SATURATE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             t,
    input  logic             M,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             ovf
);

    localparam longint unsigned RANGE_CAP = (64'd1 << WIDTH) - 64'd1;
    localparam logic [WIDTH-1:0] MAX_Q    = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ZERO_Q   = '0;
    localparam logic [WIDTH-1:0] ONE_Q    = WIDTH'(1);

    // Reject a modulus that does not fit in the counter width.
    if (WIDTH < 1) begin : g_bad_width
        $error("sync_updown_mod: WIDTH must be at least 1");
    end
    if (64'(MAX_COUNT) > RANGE_CAP) begin : g_bad_max
        $error("sync_updown_mod: MAX_COUNT exceeds 2**WIDTH-1");
    end

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] qb_r;
    logic             tc_r;
    logic             ovf_r;

    logic [WIDTH-1:0] q_nxt;
    logic             tc_nxt;
    logic             ovf_nxt;
    logic             at_top;
    logic             at_bottom;
    logic             boundary;
    logic [WIDTH-1:0] load_val;

    // Boundary detection and load clamping.
    always_comb begin
        at_top    = (q_r == MAX_Q);
        at_bottom = (q_r == ZERO_Q);
        load_val  = (d > MAX_Q) ? MAX_Q : d;
    end

    // Next-state selection: load beats counting, counting beats hold.
    always_comb begin
        q_nxt    = q_r;
        boundary = 1'b0;
        if (load) begin
            q_nxt = load_val;
        end else if (t) begin
            if (!M) begin
                if (at_top) begin
                    boundary = 1'b1;
                    q_nxt    = (SATURATE != 0) ? q_r : ZERO_Q;
                end else begin
                    q_nxt = q_r + ONE_Q;
                end
            end else begin
                if (at_bottom) begin
                    boundary = 1'b1;
                    q_nxt    = (SATURATE != 0) ? q_r : MAX_Q;
                end else begin
                    q_nxt = q_r - ONE_Q;
                end
            end
        end
        tc_nxt  = boundary;
        // A boundary event on the same edge as a clear keeps the flag set.
        ovf_nxt = boundary | (ovf_r & ~clr_ovf);
    end

    // State register; qb is registered from the same next value so it never lags q.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_r   <= '0;
            qb_r  <= '1;
            tc_r  <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            q_r   <= q_nxt;
            qb_r  <= ~q_nxt;
            tc_r  <= tc_nxt;
            ovf_r <= ovf_nxt;
        end
    end

    assign q   = q_r;
    assign qb  = qb_r;
    assign tc  = tc_r;
    assign ovf = ovf_r;

endmodule
